// File: rtl/aes_core_arbiter_if.sv
// Requester-side and aes_core-side signals of the shared AES core arbiter.
// The arbiter takes the slave view; the surrounding datapath or bench takes the master view.
interface aes_core_arbiter_if;
    logic         key_load_i;
    logic         wr_req_i;
    logic [127:0] wr_block_i;
    logic         rd_req_i;
    logic [127:0] rd_block_i;
    logic         wr_done_o;
    logic         rd_done_o;
    logic [127:0] result_o;
    logic         err_o;
    logic         key_ready_o;
    logic         busy_o;
    logic         aes_init_o;
    logic         aes_next_o;
    logic         aes_encdec_o;
    logic [127:0] aes_block_o;
    logic         aes_ready_i;
    logic         aes_valid_i;
    logic [127:0] aes_result_i;

    modport slave (
        input  key_load_i, wr_req_i, wr_block_i, rd_req_i, rd_block_i,
               aes_ready_i, aes_valid_i, aes_result_i,
        output wr_done_o, rd_done_o, result_o, err_o, key_ready_o, busy_o,
               aes_init_o, aes_next_o, aes_encdec_o, aes_block_o
    );

    modport master (
        output key_load_i, wr_req_i, wr_block_i, rd_req_i, rd_block_i,
               aes_ready_i, aes_valid_i, aes_result_i,
        input  wr_done_o, rd_done_o, result_o, err_o, key_ready_o, busy_o,
               aes_init_o, aes_next_o, aes_encdec_o, aes_block_o
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter and init/next sequencer for the shared aes_core, with key
// re-expansion on demand and a completion watchdog on both wait states.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no command in flight; key expansion has priority over grants
// KEY_INIT | aes_init pulse to start key expansion
// KEY_WAIT | waiting for the core to finish key expansion
// ISSUE    | aes_next pulse with the granted block and direction
// WAIT     | waiting for the core's result
// DONE     | done pulse to the granted port
module aes_core_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    aes_core_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_INIT,
        S_KEY_WAIT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Abort on the edge where the counter would reach TIMEOUT, so err lands
    // exactly TIMEOUT cycles after entering the wait state.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t       state;
    state_t       state_nxt;
    logic         key_pend;
    logic         key_valid;
    logic         last;
    logic         gnt;
    logic [7:0]   wd_cnt;
    logic [127:0] result_q;
    logic         err_q;

    logic         key_ready;
    logic         any_req;
    logic         pick_rd;
    logic         wait_first;
    logic         wd_expire;
    logic         in_wait;
    logic         hold_gnt;

    logic         key_start;
    logic         issue;
    logic         key_cpl;
    logic         key_abort;
    logic         blk_cpl;
    logic         blk_abort;

    assign key_ready  = key_valid & ~key_pend;
    assign any_req    = bus.wr_req_i | bus.rd_req_i;
    // On a tie the port not served last wins.
    assign pick_rd    = bus.rd_req_i & (~bus.wr_req_i | ~last);
    assign wait_first = (wd_cnt == 8'd0);
    assign wd_expire  = (wd_cnt == WD_LAST);
    assign in_wait    = (state == S_KEY_WAIT) || (state == S_WAIT);
    assign hold_gnt   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);

    always_comb begin
        state_nxt = state;
        key_start = 1'b0;
        issue     = 1'b0;
        key_cpl   = 1'b0;
        key_abort = 1'b0;
        blk_cpl   = 1'b0;
        blk_abort = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_pend && bus.aes_ready_i) begin
                    key_start = 1'b1;
                    state_nxt = S_KEY_INIT;
                end else if (key_ready && bus.aes_ready_i && any_req) begin
                    issue     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_KEY_INIT: state_nxt = S_KEY_WAIT;
            S_KEY_WAIT: begin
                if (!wait_first && bus.aes_ready_i) begin
                    key_cpl   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wd_expire) begin
                    key_abort = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!wait_first && bus.aes_ready_i && bus.aes_valid_i) begin
                    blk_cpl   = 1'b1;
                    state_nxt = S_DONE;
                end else if (wd_expire) begin
                    blk_abort = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            key_pend  <= 1'b1;
            key_valid <= 1'b0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            wd_cnt    <= 8'd0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;

            // A reload request always wins over the clear so none is lost.
            if (bus.key_load_i || key_abort) begin
                key_pend <= 1'b1;
            end else if (key_start) begin
                key_pend <= 1'b0;
            end

            if (key_cpl) begin
                key_valid <= 1'b1;
            end

            if (issue) begin
                gnt  <= pick_rd;
                last <= pick_rd;
            end

            if ((state == S_KEY_INIT) || (state == S_ISSUE)) begin
                wd_cnt <= 8'd0;
            end else if (in_wait) begin
                wd_cnt <= wd_cnt + 8'd1;
            end

            if (blk_cpl) begin
                result_q <= bus.aes_result_i;
            end else if (blk_abort) begin
                result_q <= '0;
            end

            err_q <= key_abort | blk_abort;
        end
    end

    assign bus.key_ready_o  = key_ready;
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.aes_init_o   = (state == S_KEY_INIT);
    assign bus.aes_next_o   = (state == S_ISSUE);
    assign bus.aes_encdec_o = hold_gnt & ~gnt;
    assign bus.aes_block_o  = hold_gnt ? (gnt ? bus.rd_block_i : bus.wr_block_i) : '0;
    assign bus.wr_done_o    = (state == S_DONE) & ~gnt;
    assign bus.rd_done_o    = (state == S_DONE) & gnt;
    assign bus.result_o     = result_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: a simple core model (encrypt = ~block, decrypt = block ^ 5a..5a)
// behind the arbiter, directed requests, and a scoreboard popped on every done pulse.
module tb_aes_core_arbiter;

    localparam int unsigned TIMEOUT = 255;

    typedef struct {
        bit           port;
        logic [127:0] blk;
        logic [127:0] res;
        bit           err;
    } exp_t;

    localparam logic [127:0] BLK_A  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] RES_A  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] BLK_B  = 128'hdeadbeef_00000000_ffffffff_12345678;
    localparam logic [127:0] RES_B  = 128'h84f7e4b5_5a5a5a5a_a5a5a5a5_486e0c22;
    localparam logic [127:0] BLK_W0 = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] RES_W0 = 128'hfedcba98_76543210_01234567_89abcdef;
    localparam logic [127:0] BLK_R0 = 128'h00000000_00000000_00000000_00000000;
    localparam logic [127:0] RES_R0 = 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
    localparam logic [127:0] BLK_W1 = 128'hffffffff_ffffffff_00000000_00000000;
    localparam logic [127:0] RES_W1 = 128'h00000000_00000000_ffffffff_ffffffff;
    localparam logic [127:0] BLK_R1 = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_a5a5a5a5;
    localparam logic [127:0] RES_R1 = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [127:0] BLK_RK = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] RES_RK = 128'h4b4b4b4b_78787878_69696969_1e1e1e1e;
    localparam logic [127:0] BLK_WK = 128'h00000000_00000000_00000000_00000000;
    localparam logic [127:0] RES_WK = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [127:0] BLK_RW = 128'hcafef00d_12345678_9abcdef0_0badc0de;
    localparam logic [127:0] BLK_R6 = 128'h0f0f0f0f_f0f0f0f0_0f0f0f0f_f0f0f0f0;
    localparam logic [127:0] BLK_W6 = 128'h80000000_00000000_00000000_00000001;
    localparam logic [127:0] RES_W6 = 128'h7fffffff_ffffffff_ffffffff_fffffffe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int init_cnt = 0;
    int next_cnt = 0;
    int last_init_cyc = -1;
    int last_next_cyc = -1;
    int done_cyc = -1;

    int           core_cnt = 0;
    bit           core_is_next = 1'b0;
    bit           hang = 1'b0;
    logic [127:0] core_res = '0;

    exp_t exp_q[$];

    aes_core_arbiter_if bus();

    aes_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: ready drops after a command and returns 10 cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.aes_ready_i = 1'b1;
            bus.aes_valid_i = 1'b0;
            core_cnt = 0;
        end else if (bus.aes_init_o || bus.aes_next_o) begin
            bus.aes_ready_i = 1'b0;
            bus.aes_valid_i = 1'b0;
            core_cnt = 10;
            core_is_next = bus.aes_next_o;
            core_res = bus.aes_encdec_o ? ~bus.aes_block_o : (bus.aes_block_o ^ {16{8'h5a}});
        end else if (core_cnt != 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                bus.aes_ready_i  = 1'b1;
                bus.aes_valid_i  = core_is_next && !hang;
                bus.aes_result_i = core_res;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.aes_init_o) begin
                init_cnt++;
                last_init_cyc = cyc;
            end
            if (bus.aes_next_o) begin
                next_cnt++;
                last_next_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    check("issue_encdec", bus.aes_encdec_o, !exp_q[0].port);
                    check("issue_block", bus.aes_block_o, exp_q[0].blk);
                end
            end
            if (bus.wr_done_o || bus.rd_done_o) begin
                done_cyc = cyc;
                check("done_overlap", bus.wr_done_o & bus.rd_done_o, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_port", bus.rd_done_o, e.port);
                    check("done_result", bus.result_o, e.res);
                    check("done_err", bus.err_o, e.err);
                end
            end
        end
    end

    task automatic serve(input bit port, input logic [127:0] blk);
        int   n;
        logic seen;
        n = 0;
        seen = 1'b0;
        if (port) begin
            bus.rd_block_i = blk;
            bus.rd_req_i = 1'b1;
        end else begin
            bus.wr_block_i = blk;
            bus.wr_req_i = 1'b1;
        end
        while (!seen && n < 600) begin
            @(negedge clk);
            n++;
            seen = port ? bus.rd_done_o : bus.wr_done_o;
        end
        check("req_done_seen", seen, 1);
        if (port) bus.rd_req_i = 1'b0;
        else      bus.wr_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int r, i0, n0, dc, n;
        bus.key_load_i   = 1'b0;
        bus.wr_req_i     = 1'b0;
        bus.rd_req_i     = 1'b0;
        bus.wr_block_i   = '0;
        bus.rd_block_i   = '0;
        bus.aes_ready_i  = 1'b1;
        bus.aes_valid_i  = 1'b0;
        bus.aes_result_i = '0;

        // Reset with a write request already pending; first key expansion must come first.
        rst_n = 1'b0;
        bus.wr_block_i = BLK_A;
        bus.wr_req_i   = 1'b1;
        exp_q.push_back('{1'b0, BLK_A, RES_A, 1'b0});
        repeat (3) @(negedge clk);
        check("rst_ctrl", {bus.busy_o, bus.key_ready_o, bus.wr_done_o, bus.rd_done_o,
                           bus.err_o, bus.aes_init_o, bus.aes_next_o, bus.aes_encdec_o}, 0);
        check("rst_block", bus.aes_block_o, 0);
        check("rst_result", bus.result_o, 0);
        rst_n = 1'b1;
        fork
            serve(1'b0, BLK_A);
            begin
                int k;
                k = 0;
                while (!bus.key_ready_o && k < 60) begin
                    @(negedge clk);
                    k++;
                end
                check("key_ready_latency", k, 12);
                check("first_init_count", init_cnt, 1);
                check("no_issue_before_key", next_cnt, 0);
            end
        join
        @(negedge clk);

        // Single decrypt with latency checks.
        exp_q.push_back('{1'b1, BLK_B, RES_B, 1'b0});
        r = cyc;
        serve(1'b1, BLK_B);
        @(negedge clk);
        check("issue_latency", last_next_cyc - r, 1);
        check("done_latency", done_cyc - last_next_cyc, 11);

        // Tie fairness: both ports request back to back.
        exp_q.push_back('{1'b0, BLK_W0, RES_W0, 1'b0});
        exp_q.push_back('{1'b1, BLK_R0, RES_R0, 1'b0});
        exp_q.push_back('{1'b0, BLK_W1, RES_W1, 1'b0});
        exp_q.push_back('{1'b1, BLK_R1, RES_R1, 1'b0});
        fork
            begin
                serve(1'b0, BLK_W0);
                @(negedge clk);
                serve(1'b0, BLK_W1);
            end
            begin
                serve(1'b1, BLK_R0);
                @(negedge clk);
                serve(1'b1, BLK_R1);
            end
        join
        @(negedge clk);
        check("tie_queue_empty", exp_q.size(), 0);

        // Watchdog: core never returns valid.
        hang = 1'b1;
        exp_q.push_back('{1'b1, BLK_RW, 128'h0, 1'b1});
        serve(1'b1, BLK_RW);
        @(negedge clk);
        check("wd_span", done_cyc - last_next_cyc, 256);
        check("wd_back_idle", bus.busy_o, 0);
        check("wd_err_one_cycle", bus.err_o, 0);
        check("wd_result_zero", bus.result_o, 0);
        hang = 1'b0;

        // Key reload during WAIT of a read.
        exp_q.push_back('{1'b1, BLK_RK, RES_RK, 1'b0});
        exp_q.push_back('{1'b0, BLK_WK, RES_WK, 1'b0});
        fork
            serve(1'b1, BLK_RK);
            begin
                int k, c0;
                k = 0;
                c0 = next_cnt;
                while (next_cnt == c0 && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                check("reload_issue_seen", next_cnt, c0 + 1);
                repeat (3) @(negedge clk);
                bus.key_load_i = 1'b1;
                @(negedge clk);
                bus.key_load_i = 1'b0;
                check("reload_key_ready_low", bus.key_ready_o, 0);
            end
        join
        @(negedge clk);
        i0 = init_cnt;
        dc = done_cyc;
        serve(1'b0, BLK_WK);
        @(negedge clk);
        check("reload_init_count", init_cnt, i0 + 1);
        check("reload_init_after_done", last_init_cyc > dc, 1);
        check("reload_init_before_next", last_next_cyc > last_init_cyc, 1);
        check("reload_key_ready_back", bus.key_ready_o, 1);

        // Asynchronous reset in the middle of WAIT.
        exp_q.push_back('{1'b1, BLK_R6, 128'h0, 1'b0});
        n0 = next_cnt;
        n = 0;
        bus.rd_block_i = BLK_R6;
        bus.rd_req_i   = 1'b1;
        while (next_cnt == n0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstw_issue_seen", next_cnt, n0 + 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ctrl", {bus.busy_o, bus.key_ready_o, bus.wr_done_o, bus.rd_done_o,
                            bus.err_o, bus.aes_init_o, bus.aes_next_o, bus.aes_encdec_o}, 0);
        check("rstw_block", bus.aes_block_o, 0);
        check("rstw_result", bus.result_o, 0);
        bus.rd_req_i = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        i0 = init_cnt;
        n0 = next_cnt;
        rst_n = 1'b1;
        exp_q.push_back('{1'b0, BLK_W6, RES_W6, 1'b0});
        serve(1'b0, BLK_W6);
        @(negedge clk);
        check("rstw_fresh_init", init_cnt, i0 + 1);
        check("rstw_single_issue", next_cnt, n0 + 1);
        check("rstw_init_before_next", last_next_cyc > last_init_cyc, 1);

        repeat (2) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
